// File: rtl/mag_controle_pwm.sv
// Magnetron controller: start/pause/resume/clear state machine with power levels
// produced by duty-cycling the magnetron over a period of LEVELS slots.
module mag_controle_pwm #(
    parameter int LEVELS      = 10,
    parameter int SLOT_CYCLES = 4,
    parameter int LW          = $clog2(LEVELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startn,
    input  logic          stopn,
    input  logic          clearn,
    input  logic          door_closed,
    input  logic          timer_done,
    input  logic [LW-1:0] power_level,
    output logic          mag_on,
    output logic          cooking,
    output logic          paused,
    output logic          done_pulse,
    output logic [LW-1:0] level_q
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(LEVELS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(LEVELS - 1);
    localparam logic [LW-1:0] LVL_MAX  = LW'(LEVELS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] slot_cnt_r, slot_cnt_s;
    logic [IW-1:0] slot_idx_r, slot_idx_s;
    logic [LW-1:0] level_r, level_s;
    logic          startn_prev_r;
    logic          start_ev_s;
    logic [LW-1:0] level_clamped_s;

    assign start_ev_s      = ~startn & startn_prev_r;
    assign level_clamped_s = (power_level > LVL_MAX) ? LVL_MAX : power_level;

    // State, PWM counters, applied level and start-edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            slot_cnt_r    <= '0;
            slot_idx_r    <= '0;
            level_r       <= '0;
            startn_prev_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            slot_cnt_r    <= slot_cnt_s;
            slot_idx_r    <= slot_idx_s;
            level_r       <= level_s;
            startn_prev_r <= startn;
        end
    end

    // Next-state logic; clear > stop > door open > timer > start
    always_comb begin
        state_s    = state_r;
        slot_cnt_s = slot_cnt_r;
        slot_idx_s = slot_idx_r;
        level_s    = level_r;
        case (state_r)
            ST_IDLE: begin
                if (clearn && stopn && door_closed && start_ev_s &&
                    (level_clamped_s != {LW{1'b0}})) begin
                    state_s    = ST_COOKING;
                    level_s    = level_clamped_s;
                    slot_cnt_s = '0;
                    slot_idx_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COOKING: begin
                if (!clearn) begin
                    state_s = ST_IDLE;
                end else if (!stopn || !door_closed) begin
                    state_s = ST_PAUSED;
                end else if (timer_done) begin
                    state_s = ST_DONE;
                end else if (slot_cnt_r == CNT_LAST) begin
                    slot_cnt_s = '0;
                    if (slot_idx_r == IDX_LAST) begin
                        // Period boundary: the only point a new level is taken
                        slot_idx_s = '0;
                        level_s    = level_clamped_s;
                    end else begin
                        slot_idx_s = slot_idx_r + 1'b1;
                    end
                end else begin
                    slot_cnt_s = slot_cnt_r + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (!clearn) begin
                    state_s = ST_IDLE;
                end else if (start_ev_s && door_closed && stopn) begin
                    state_s = ST_COOKING;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_IDLE) begin
            slot_cnt_s = '0;
            slot_idx_s = '0;
            level_s    = '0;
        end else begin
            level_s = level_s;
        end
    end

    // Door interlock stays combinational so opening the door cuts power at once
    assign mag_on     = (state_r == ST_COOKING) && (LW'(slot_idx_r) < level_r) && door_closed;
    assign cooking    = (state_r == ST_COOKING);
    assign paused     = (state_r == ST_PAUSED);
    assign done_pulse = (state_r == ST_DONE);
    assign level_q    = level_r;

endmodule

// File: tb/tb_mag_controle_pwm.sv
// Bench for mag_controle_pwm: directed scenarios followed by random stimulus,
// every cycle compared against a period-position reference model.
module tb_mag_controle_pwm;

    localparam int L  = 4;
    localparam int SC = 2;
    localparam int P  = L * SC;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst, startn, stopn, clearn, door_closed, timer_done;
    logic [LW-1:0] power_level;
    logic          mag_on, cooking, paused, done_pulse;
    logic [LW-1:0] level_q;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 cooking, 2 paused, 3 done; pos = cycle in period
    int m_mode, m_pos, m_level;
    bit m_prev;

    mag_controle_pwm #(.LEVELS(L), .SLOT_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
        .mag_on(mag_on), .cooking(cooking), .paused(paused), .done_pulse(done_pulse),
        .level_q(level_q)
    );

    always #5 clk = ~clk;

    function automatic int clamp(int v);
        return (v > L) ? L : v;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_on;
        exp_on = ((m_mode == 1) && ((m_pos / SC) < m_level) && door_closed) ? 8'd1 : 8'd0;
        chk("mag_on", {7'd0, mag_on}, exp_on);
        chk("cooking", {7'd0, cooking}, (m_mode == 1) ? 8'd1 : 8'd0);
        chk("paused", {7'd0, paused}, (m_mode == 2) ? 8'd1 : 8'd0);
        chk("done_pulse", {7'd0, done_pulse}, (m_mode == 3) ? 8'd1 : 8'd0);
        chk("level_q", {5'd0, level_q}, 8'(m_level));
    endtask

    task automatic model_step();
        bit sev;
        sev    = (startn == 1'b0) && m_prev;
        m_prev = startn;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_level = 0; m_prev = 1'b1;
            return;
        end
        case (m_mode)
            0: if (clearn && stopn && door_closed && sev && clamp(int'(power_level)) != 0) begin
                   m_mode = 1; m_pos = 0; m_level = clamp(int'(power_level));
               end
            1: if (!clearn) m_mode = 0;
               else if (!stopn || !door_closed) m_mode = 2;
               else if (timer_done) m_mode = 3;
               else begin
                   m_pos = (m_pos + 1) % P;
                   if (m_pos == 0) m_level = clamp(int'(power_level));
               end
            2: if (!clearn) m_mode = 0;
               else if (sev && door_closed && stopn) m_mode = 1;
            default: m_mode = 0;
        endcase
        if (m_mode == 0) begin
            m_pos = 0; m_level = 0;
        end
    endtask

    // Check outputs for current inputs, then clock and advance the model
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press();
        startn = 1'b0; tick();
        startn = 1'b1;
    endtask

    task automatic clear_out();
        clearn = 1'b0; tick();
        clearn = 1'b1;
    endtask

    initial begin
        int ons;
        rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = '0;
        @(posedge clk);
        model_step();
        #1;
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) tick();
        chk("idle_level", {5'd0, level_q}, 8'd0);

        // Level 1: 2 of every 8 cycles on
        power_level = 3'd1;
        press();
        chk("start_cooking", {7'd0, cooking}, 8'd1);
        ons = 0;
        for (int i = 0; i < 16; i++) begin
            ons += int'(mag_on);
            tick();
        end
        chk("duty_l1", 8'(ons), 8'd4);
        clear_out();

        // Level 6 clamps to 4, then change to 2 mid-period
        power_level = 3'd6;
        press();
        chk("clamp_level", {5'd0, level_q}, 8'd4);
        for (int i = 0; i < 3; i++) tick();
        power_level = 3'd2;
        ons = 0;
        for (int i = 0; i < 5; i++) begin
            ons += int'(mag_on);
            tick();
        end
        chk("hold_level", 8'(ons), 8'd5);
        ons = 0;
        for (int i = 0; i < 8; i++) begin
            ons += int'(mag_on);
            tick();
        end
        chk("duty_l2", 8'(ons), 8'd4);
        chk("new_level", {5'd0, level_q}, 8'd2);
        clear_out();

        // Door opens during an on-slot, then resume
        press();
        tick();
        door_closed = 1'b0;
        #1 chk("door_interlock", {7'd0, mag_on}, 8'd0);
        tick();
        chk("door_paused", {7'd0, paused}, 8'd1);
        tick();
        door_closed = 1'b1;
        tick();
        press();
        for (int i = 0; i < 10; i++) tick();

        // Timer completion
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        chk("done_pulse", {7'd0, done_pulse}, 8'd1);
        tick();
        chk("after_done", {6'd0, cooking, mag_on}, 8'd0);

        // Clear with start in idle, level 0 start, door-open start
        clearn = 1'b0; press(); clearn = 1'b1;
        chk("clear_wins", {7'd0, cooking}, 8'd0);
        tick();
        power_level = 3'd0; press();
        chk("level0_start", {7'd0, cooking}, 8'd0);
        tick();
        power_level = 3'd3; door_closed = 1'b0; press(); door_closed = 1'b1;
        chk("door_start", {7'd0, cooking}, 8'd0);
        tick();

        // Reset mid-cook
        press();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("reset_out", {3'd0, mag_on, cooking, paused, done_pulse, 1'b0}, 8'd0);
        tick();

        // Random stimulus against the model
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            clearn      = ($urandom_range(0, 39) != 0);
            stopn       = ($urandom_range(0, 19) != 0);
            door_closed = ($urandom_range(0, 19) != 0);
            timer_done  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) startn = ~startn;
            if ($urandom_range(0, 7) == 0) power_level = LW'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mag_controle_pwm.md
# mag_controle_pwm

Clocked, parametrised magnetron controller for the microwave datapath. It replaces the level-only on/off magnetron control with a state machine that supports start, pause/resume and clear, plus selectable power levels. Each power level is produced by duty-cycling the magnetron over a fixed period. It sits between the front-panel/door/timer signals and the magnetron driver.

## Interface
- `LEVELS`, 10: number of power steps; period = `LEVELS` slots; must be ≥ 2.
- `SLOT_CYCLES`, 4: clock cycles per slot; must be ≥ 1.
- `LW`, `$clog2(LEVELS+1)`: derived width of power-level ports; not overridden.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `startn`  in  1  start button, active-low; acts on falling edge only.
- `stopn`  in  1  stop request, active-low level.
- `clearn`  in  1  clear/cancel, active-low level.
- `door_closed`  in  1  1 = door closed.
- `timer_done`  in  1  cook timer expired, level.
- `power_level`  in  LW  requested power, 0..LEVELS; values > LEVELS clamp to LEVELS.
- `mag_on`  out  1  magnetron enable.
- `cooking`  out  1  state == COOKING.
- `paused`  out  1  state == PAUSED.
- `done_pulse`  out  1  one-cycle pulse on completion.
- `level_q`  out  LW  power level currently applied.

## Operation
- All inputs are synchronous to `clk`.
- `start_ev` = `startn`==0 and registered previous `startn`==1.
- States are IDLE, COOKING, PAUSED and DONE.
- Per-cycle priority: clear > stop > door open > timer_done > start.
- IDLE:
  - `start_ev` & `door_closed` & clamped `power_level` ≠ 0 → COOKING.
  - On that entry: load `level_q` with clamped `power_level`; set `slot_cnt`=0 and `slot_idx`=0.
  - A start with level 0 or the door open is ignored.
- COOKING:
  - `clearn`=0 → IDLE.
  - Otherwise `stopn`=0 or `door_closed`=0 → PAUSED.
  - Otherwise `timer_done`=1 → DONE.
  - Otherwise counters advance. `slot_cnt` counts 0..SLOT_CYCLES-1 and wraps. On its wrap, `slot_idx` counts 0..LEVELS-1 and wraps.
  - When `slot_idx` wraps to 0, `level_q` reloads from clamped `power_level`. A reload value of 0 means the magnetron stays off for that period; the state does not change.
- PAUSED:
  - Counters and `level_q` hold.
  - `clearn`=0 → IDLE.
  - `start_ev` & `door_closed` & `stopn`=1 → COOKING, resuming from the held counters with no reset.
  - `timer_done` is ignored.
- DONE: lasts one cycle, then → IDLE. `done_pulse`=1 only in this state.
- Entry to IDLE clears the counters and `level_q`.
- `mag_on` = (state==COOKING) & (`slot_idx` < `level_q`) & `door_closed`.
  - The combinational door interlock is mandatory: the door opening drops `mag_on` in the same cycle.
- Duty = `level_q`/LEVELS. The on-time is contiguous at the start of each period.

## Timing
- Reset values:
  - state IDLE; counters 0; `level_q`=0; previous-`startn` register=1.
  - `mag_on`, `cooking`, `paused` and `done_pulse` are 0.
- Reset mid-cook returns to IDLE on the next edge. `mag_on` is 0 in the following cycle.
- A `start_ev` sampled at edge t gives COOKING from t+1. `mag_on`=1 at t+1 if `level_q` ≥ 1.
- Stop, clear or `timer_done` sampled at edge t drops `mag_on` from t+1. A door open drops it immediately (combinational).
- Holding `startn` low produces exactly one `start_ev`. It must be released and pressed again to restart or resume.
- Simultaneous start and clear in IDLE: clear wins, so the state stays IDLE.
- Simultaneous `timer_done` and stop in COOKING: the block goes to PAUSED.
- A `power_level` change mid-period has no effect until the next period boundary.

## Test plan
All scenarios use `LEVELS`=4 and `SLOT_CYCLES`=2, giving an 8-cycle period.

- Reset then idle with `startn`=1 → all outputs 0, `level_q`=0 for 20 cycles.
- `door_closed`=1, `power_level`=1, pulse `startn` low 1 cycle → `cooking`=1 next cycle; `mag_on` high 2 of every 8 cycles, repeating.
- Same with `power_level`=4, then 6 → `mag_on` is constantly 1 and `level_q`=4 (clamped). Change to level 2 mid-period → takes effect at the next `slot_idx` wrap (4 on / 4 off).
- Cooking at level 2, drop `door_closed` during an on-slot → `mag_on`=0 in the same cycle and `paused`=1 next cycle. Close the door and press start → resumes with the counters unchanged.
- Cooking, assert `timer_done` → one cycle `done_pulse`=1, then IDLE with `mag_on`=0. Separately, `clearn`=0 together with `startn` falling in IDLE → stays IDLE.
- Start with `power_level`=0 or `door_closed`=0 → state stays IDLE. Assert `rst` while cooking → all outputs 0 after the next edge.
